// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard scan-code decoder. It handles E0/F0 prefixes, requests a resend on receive
// errors, queues events in a FIFO, and tracks the left/right arrow held state.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the held arrow keys.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       left_held,
  output logic       right_held,
  output logic       ovf,
  input  logic       clr_ovf
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TCW = $clog2(PREFIX_TIMEOUT + 1);
  localparam int TW  = (TCW > 17) ? TCW : 17;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, RESEND} state_t;

  state_t        state_q, state_d, saved_q, saved_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ignore, push, ev_ext, ev_brk, fifo_push;
  logic          mk_l, mk_r, brk_l, brk_r;

  assign ignore = (rx_data == 8'hFA) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                  (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      saved_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    timer_d = timer_q;
    push    = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (state_q == RESEND) begin
      // Timer stays frozen so a restored prefix keeps its remaining lifetime.
      if (tx_done) state_d = saved_q;
    end else if (rx_valid) begin
      timer_d = '0;
      if (rx_err) begin
        saved_d = state_q;
        state_d = RESEND;
      end else if (!ignore) begin
        if (rx_data == 8'hE0) begin
          state_d = (state_q == IDLE || state_q == EXT) ? EXT : IDLE;
        end else if (rx_data == 8'hF0) begin
          state_d = (state_q == IDLE) ? BRK : (state_q == EXT) ? EXT_BRK : IDLE;
        end else begin
          push    = 1'b1;
          ev_ext  = (state_q == EXT) || (state_q == EXT_BRK);
          ev_brk  = (state_q == BRK) || (state_q == EXT_BRK);
          state_d = IDLE;
        end
      end
    end else if (state_q == IDLE || timer_q == TMO_LAST) begin
      timer_d = '0;
      state_d = IDLE;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign tx_req  = (state_q == RESEND);
  assign tx_data = tx_req ? 8'hFE : 8'h00;

  assign mk_l  = push & ev_ext & ~ev_brk & (rx_data == 8'h6B);
  assign brk_l = push & ev_ext &  ev_brk & (rx_data == 8'h6B);
  assign mk_r  = push & ev_ext & ~ev_brk & (rx_data == 8'h74);
  assign brk_r = push & ev_ext &  ev_brk & (rx_data == 8'h74);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_held  <= 1'b0;
      right_held <= 1'b0;
    end else begin
      if (mk_l)       left_held  <= 1'b1;
      else if (brk_l) left_held  <= 1'b0;
      if (mk_r)       right_held <= 1'b1;
      else if (brk_r) right_held <= 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign fifo_push = push & ~(mk_l & left_held) & ~(mk_r & right_held);
`else
  assign fifo_push = push;
`endif

  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0]  mem [FIFO_DEPTH];
  logic [9:0]  head;
  logic        full, pop, do_wr, overflow;

  assign evt_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = evt_valid & evt_ready;
  assign do_wr     = fifo_push & (~full | pop);
  assign overflow  = fifo_push & full & ~pop;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_ext   = evt_valid & head[9];
  assign evt_break = evt_valid & head[8];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= {ev_ext, ev_brk, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (overflow)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomised bench for ps2_key_ctrl: a byte-level reference model feeds an expected-event
// queue that a monitor drains on every accepted FIFO handshake.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx_valid = 1'b0, rx_err = 1'b0, tx_done = 1'b0, evt_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_req, evt_valid, evt_ext, evt_break, left_held, right_held, ovf;
  logic [7:0] tx_data, evt_code;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .left_held(left_held), .right_held(right_held),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] code; bit ext; bit brk;} ev_t;
  ev_t exp_q[$];

  int  vectors = 0, miscompares = 0;
  int  rdy_pct = 100, clr_pct = 0;
  int  mocc = 0, m_age = 0;
  bit  m_ext = 0, m_brk = 0, m_res = 0, s_ext = 0, s_brk = 0;
  bit  exp_left = 0, exp_right = 0, exp_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending prefixes as flags, FIFO as an occupancy count.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      mocc = 0; m_age = 0; m_ext = 0; m_brk = 0; m_res = 0; s_ext = 0; s_brk = 0;
      exp_left = 0; exp_right = 0; exp_ovf = 0;
    end else begin
      bit  pop, emit, ovfl;
      ev_t ev;
      pop = (mocc > 0) && evt_ready;
      emit = 0; ovfl = 0;
      ev = '{8'h00, 1'b0, 1'b0};
      if (m_res) begin
        if (tx_done) begin m_res = 0; m_ext = s_ext; m_brk = s_brk; end
      end else if (rx_valid) begin
        m_age = 0;
        if (rx_err) begin
          s_ext = m_ext; s_brk = m_brk; m_res = 1; m_ext = 0; m_brk = 0;
        end else if (rx_data inside {8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF}) begin
        end else if (rx_data == 8'hE0) begin
          if (m_brk) begin m_ext = 0; m_brk = 0; end else m_ext = 1;
        end else if (rx_data == 8'hF0) begin
          if (m_brk) begin m_ext = 0; m_brk = 0; end else m_brk = 1;
        end else begin
          ev = '{rx_data, m_ext, m_brk};
          emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (m_ext && !m_brk && ((rx_data == 8'h6B && exp_left) || (rx_data == 8'h74 && exp_right)))
            emit = 0;
`endif
          if (m_ext && rx_data == 8'h6B) exp_left  = !m_brk;
          if (m_ext && rx_data == 8'h74) exp_right = !m_brk;
          m_ext = 0; m_brk = 0;
        end
      end else if (m_ext || m_brk) begin
        m_age++;
        if (m_age >= TMO) begin m_ext = 0; m_brk = 0; m_age = 0; end
      end
      if (emit) begin
        if (mocc < DEPTH || pop) begin exp_q.push_back(ev); mocc++; end
        else ovfl = 1;
      end
      if (pop) mocc--;
      if (ovfl) exp_ovf = 1;
      else if (clr_ovf) exp_ovf = 0;
    end
  end

  // Monitor: sampled mid-cycle, pops the scoreboard on every handshake.
  initial forever begin
    @(negedge clk);
    chk("evt_valid", evt_valid, mocc != 0);
    chk("left_held", left_held, exp_left);
    chk("right_held", right_held, exp_right);
    chk("ovf", ovf, exp_ovf);
    chk("tx_req", tx_req, m_res);
    chk("tx_data", tx_data, m_res ? 8'hFE : 8'h00);
    if (!rst_n) begin
      chk("rst_evt_code", evt_code, 8'h00);
      chk("rst_evt_flags", {evt_ext, evt_break}, 2'b00);
    end else if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("evt_unexpected", {evt_ext, evt_break, evt_code}, 10'h3FF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("evt_code", evt_code, e.code);
        chk("evt_ext", evt_ext, e.ext);
        chk("evt_break", evt_break, e.brk);
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit e);
    @(posedge clk);
    #2;
    rx_valid  = v;
    rx_data   = d;
    rx_err    = e;
    evt_ready = ($urandom_range(1, 100) <= rdy_pct);
    clr_ovf   = ($urandom_range(1, 100) <= clr_pct);
    tx_done   = tx_req && ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0);
  endtask

  task automatic send(input logic [7:0] d, input bit e = 0);
    cyc(1, d, e);
    idle($urandom_range(0, 2));
  endtask

  task automatic settle_resend();
    for (int i = 0; i < 200 && (tx_req || m_res); i++) cyc(0, 8'h00, 0);
    chk("resend_timeout", tx_req, 1'b0);
  endtask

  logic [7:0] ign [5] = '{8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF};
  logic [7:0] mk5 [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};

  initial begin
    idle(3);
    #1 rst_n = 1'b1;
    idle(2);
    // Arrow make then extended break.
    rdy_pct = 70;
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    // Errored byte, resend, then the good retry.
    send(8'h1C, 1); settle_resend(); send(8'h1C);
    // Overflow with a stalled consumer, then clear.
    rdy_pct = 0; idle(4);
    for (int i = 0; i < 5; i++) send(mk5[i]);
    idle(3);
    clr_pct = 100; idle(1); clr_pct = 0; rdy_pct = 100; idle(8);
    // Stale prefix times out.
    send(8'hE0); idle(TMO + 5); send(8'h74);
    // Typematic repeats.
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h74); end
    idle(6);
    // Reset in EXT_BRK abandons the pending release.
    send(8'hE0); send(8'hF0);
    rst_n = 1'b0; idle(3); rst_n = 1'b1; idle(1);
    send(8'h6B); idle(4);
    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      if (n % 200 == 0) rdy_pct = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(30, 100);
      clr_pct = ($urandom_range(0, 9) == 0) ? 5 : 0;
      case ($urandom_range(0, 9))
        0, 1: b = 8'hE0;
        2:    b = 8'hF0;
        3:    b = 8'h6B;
        4:    b = 8'h74;
        5:    b = ign[$urandom_range(0, 4)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      cyc(1, b, $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) idle($urandom_range(TMO - 5, TMO + 8));
      else idle($urandom_range(0, 3));
    end
    rdy_pct = 100; clr_pct = 0;
    settle_resend();
    idle(DEPTH + 6);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 Parameter PREFIX_TIMEOUT, default 50000, clk cycles a pending E0/F0 prefix survives without a following byte.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx_valid  input  1  one-cycle pulse, received PS/2 byte present.
REQ-006 rx_data  input  8  received byte, qualified by rx_valid.
REQ-007 rx_err  input  1  parity/framing error flag, qualified by rx_valid.
REQ-008 tx_req  output  1  request to send tx_data to keyboard; level, held until tx_done.
REQ-009 tx_data  output  8  command byte to transmit.
REQ-010 tx_done  input  1  one-cycle pulse, transmitter finished the byte.
REQ-011 evt_valid  output  1  FIFO head event valid (FIFO not empty).
REQ-012 evt_ready  input  1  consumer accepts head; pop when evt_valid & evt_ready.
REQ-013 evt_code  output  8  head event scan code.
REQ-014 evt_ext  output  1  head event had E0 prefix.
REQ-015 evt_break  output  1  head event is a release (F0 prefix).
REQ-016 left_held  output  1  left arrow (E0 6B) currently pressed.
REQ-017 right_held  output  1  right arrow (E0 74) currently pressed.
REQ-018 ovf  output  1  sticky FIFO overflow flag.
REQ-019 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-020 FSM states: IDLE, EXT, BRK, EXT_BRK, RESEND.
REQ-021 Good byte = rx_valid & !rx_err; bytes FA, AA, EE, 00, FF are ignored in every state, no state change.
REQ-022 IDLE: E0 -> EXT; F0 -> BRK; other -> push {code, ext=0, break=0}, stay IDLE.
REQ-023 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {code,1,0}, IDLE.
REQ-024 BRK: other -> push {code,0,1}, IDLE; EXT_BRK: other -> push {code,1,1}, IDLE; E0/F0 in BRK/EXT_BRK -> IDLE, no push.
REQ-025 rx_valid & rx_err in any non-RESEND state -> RESEND, tx_req=1, tx_data=FE; prefix state before the error is saved and restored on tx_done.
REQ-026 In RESEND all rx_valid bytes are dropped; tx_req deasserts the cycle after tx_done.
REQ-027 Prefix timer: 17-bit-or-wider counter, cleared on every rx_valid and in IDLE; in EXT/BRK/EXT_BRK reaching PREFIX_TIMEOUT -> IDLE, no push; frozen in RESEND.
REQ-028 Push latency: event visible on evt_* the cycle after the rx_valid cycle when FIFO was empty.
REQ-029 FIFO full and push without pop: event dropped, ovf set next cycle; full with simultaneous push and pop: both performed, no ovf.
REQ-030 clr_ovf and new overflow in same cycle: ovf stays 1.
REQ-031 left_held/right_held set on ext make 6B/74, cleared on ext break 6B/74, one cycle after rx_valid, independent of FIFO state/overflow; non-ext 6B/74 do not affect them.

Reset
REQ-032 rst_n low: state IDLE, FIFO empty, evt_valid=0, evt_code=00, evt_ext=0, evt_break=0, tx_req=0, tx_data=00, left_held=0, right_held=0, ovf=0, timer=0.
REQ-033 Reset mid-RESEND or mid-prefix abandons the sequence; no event emitted after release.

Configuration
REQ-034 Macro PS2_TYPEMATIC_FILTER_EN defined: ext make 6B while left_held=1, or ext make 74 while right_held=1, is not pushed (typematic repeats suppressed); undefined: every make is pushed.

Verification
REQ-035 Bytes E0,6B then E0,F0,6B -> events {6B,1,0},{6B,1,1}; left_held 1 then 0.
REQ-036 Byte 1C with rx_err=1 -> tx_req=1, tx_data=FE until tx_done; then 1C good -> event {1C,0,0}.
REQ-037 evt_ready=0, push 5 makes with FIFO_DEPTH=4 -> 4 events retained, ovf=1; clr_ovf -> ovf=0.
REQ-038 E0 then no byte for PREFIX_TIMEOUT cycles, then 74 -> event {74,0,0}, right_held=0.
REQ-039 E0,74 three times -> with PS2_TYPEMATIC_FILTER_EN 1 event, without 3 events; right_held=1 both.
REQ-040 rst_n low during EXT_BRK, release, send 6B -> event {6B,0,0}, all outputs reset values during reset.
